key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 171 +++++++++++++++++
 tb/tb_key_debounce.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Note-key and octave-button front end: synchronizes and debounces seven note
// switches and two octave buttons. Drives a priority-encoded one-hot note select
// and a three-level octave indication.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_raw,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       a,
  output logic       b,
  output logic       note_valid,
  output logic       up,
  output logic       down
);

  localparam int unsigned NumIn = 9;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StLow, StMid, StHigh} oct_e;

  // Bit layout: [6:0] note keys C..B, [7] octave up, [8] octave down.
  logic [NumIn-1:0] raw_all;
  logic [NumIn-1:0] sync1_q, sync2_q;
  logic [NumIn-1:0] stable_q, stable_d;
  logic [CntW-1:0]  cnt_q [NumIn];
  logic [CntW-1:0]  cnt_d [NumIn];

  logic [6:0] note_sel;
  logic [6:0] note_q;

  logic  up_prev_q, down_prev_q;
  logic  up_edge, down_edge;
  oct_e  state_q, state_d;
  logic  up_d, down_d;

  assign raw_all = {btn_down_raw, btn_up_raw, key_raw};

  // Two-flop synchronizer for every raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_all;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: count consecutive cycles of disagreement, accept on the last one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NumIn; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Fixed-priority select: scan from B down to C so the lowest index wins.
  always_comb begin
    note_sel = '0;
    for (int i = 6; i >= 0; i--) begin
      if (stable_q[i]) begin
        note_sel    = '0;
        note_sel[i] = 1'b1;
      end
    end
  end

  // Registered note select and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_q     <= '0;
      note_valid <= 1'b0;
    end else begin
      note_q     <= note_sel;
      note_valid <= |stable_q[6:0];
    end
  end

  assign c = note_q[0];
  assign d = note_q[1];
  assign e = note_q[2];
  assign f = note_q[3];
  assign g = note_q[4];
  assign a = note_q[5];
  assign b = note_q[6];

  assign up_edge   = stable_q[7] & ~up_prev_q;
  assign down_edge = stable_q[8] & ~down_prev_q;

  // Octave state register and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StMid;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      up_prev_q   <= stable_q[7];
      down_prev_q <= stable_q[8];
    end
  end

  // Octave next state: saturating step, simultaneous edges cancel.
  always_comb begin
    state_d = state_q;
    if (up_edge && !down_edge) begin
      unique case (state_q)
        StLow:   state_d = StMid;
        StMid:   state_d = StHigh;
        StHigh:  state_d = StHigh;
        default: state_d = StMid;
      endcase
    end else if (down_edge && !up_edge) begin
      unique case (state_q)
        StLow:   state_d = StLow;
        StMid:   state_d = StLow;
        StHigh:  state_d = StMid;
        default: state_d = StMid;
      endcase
    end
  end

  // Octave output decode from the next state so outputs move on the same edge as the state.
  always_comb begin
    up_d   = (state_d == StHigh);
    down_d = (state_d == StLow);
  end

  // Registered octave indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      up   <= 1'b0;
      down <= 1'b0;
    end else begin
      up   <= up_d;
      down <= down_d;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: a sample-window reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bouncy stimulus.
module tb_key_debounce;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] key_raw = '0;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic       c, d, e, f, g, a, b, note_valid, up, down;
  logic [9:0] dut_out;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  key_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_raw      (key_raw),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .c            (c),
    .d            (d),
    .e            (e),
    .f            (f),
    .g            (g),
    .a            (a),
    .b            (b),
    .note_valid   (note_valid),
    .up           (up),
    .down         (down)
  );

  assign dut_out = {c, d, e, f, g, a, b, note_valid, up, down};

  // Reference model: an input's stable value flips once the last N synchronized
  // samples all disagree with it; synchronized sample = raw seen two edges earlier.
  logic [8:0] hist[$];
  logic [8:0] m_raw, m_stab;
  logic [6:0] m_notes;
  logic       m_up_prev, m_dn_prev, m_upe, m_dne, m_flip;
  int         m_oct, m_first;
  logic [9:0] exp_out = '0;

  initial begin
    for (int i = 0; i <= N; i++) hist.push_back('0);
    m_stab = '0;
    m_oct  = 1;
  end

  always @(posedge clk) begin
    m_raw = {btn_down_raw, btn_up_raw, key_raw};
    if (rst) begin
      hist.delete();
      for (int i = 0; i <= N; i++) hist.push_back('0);
      m_stab    = '0;
      m_up_prev = 1'b0;
      m_dn_prev = 1'b0;
      m_oct     = 1;
      exp_out   = '0;
    end else begin
      m_first = -1;
      for (int i = 6; i >= 0; i--) if (m_stab[i]) m_first = i;
      m_notes = '0;
      if (m_first >= 0) m_notes[m_first] = 1'b1;
      m_upe = m_stab[7] && !m_up_prev;
      m_dne = m_stab[8] && !m_dn_prev;
      if (m_upe && !m_dne && m_oct < 2) m_oct++;
      else if (m_dne && !m_upe && m_oct > 0) m_oct--;
      m_up_prev = m_stab[7];
      m_dn_prev = m_stab[8];
      exp_out = {m_notes[0], m_notes[1], m_notes[2], m_notes[3], m_notes[4], m_notes[5],
                 m_notes[6], (m_first >= 0), (m_oct == 2), (m_oct == 0)};
      for (int j = 0; j < 9; j++) begin
        m_flip = 1'b1;
        for (int k = 0; k < N; k++) if (hist[k][j] == m_stab[j]) m_flip = 1'b0;
        if (m_flip) m_stab[j] = ~m_stab[j];
      end
      void'(hist.pop_front());
      hist.push_back(m_raw);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      total++;
      if (dut_out !== exp_out) begin
        bad++;
        $display("FAIL model_cmp t=%0t got %b expected %b", $time, dut_out, exp_out);
      end
    end
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic press(input bit is_up);
    if (is_up) btn_up_raw = 1'b1; else btn_down_raw = 1'b1;
    tick(8);
    if (is_up) btn_up_raw = 1'b0; else btn_down_raw = 1'b0;
    tick(8);
  endtask

  int         hold[9];
  logic [8:0] rv;

  initial begin
    // Reset with garbage on the inputs.
    key_raw = 7'b1011011;
    btn_up_raw = 1'b1;
    tick(3);
    check("reset_outputs", dut_out, 10'b0);
    cmp_en = 1'b1;
    rst = 1'b0;
    key_raw = '0;
    btn_up_raw = 1'b0;
    tick(10);

    // Clean E press and release: N+3 edges each way.
    key_raw = 7'b0000100;
    tick(6);
    check("e_before_latency", {9'b0, e}, 10'd0);
    tick(1);
    check("e_at_latency", {9'b0, e}, 10'd1);
    check("valid_at_latency", {9'b0, note_valid}, 10'd1);
    key_raw = '0;
    tick(6);
    check("e_release_before", {9'b0, e}, 10'd1);
    tick(1);
    check("e_release_at", {9'b0, e}, 10'd0);
    check("valid_release_at", {9'b0, note_valid}, 10'd0);
    tick(4);

    // Glitch train on C is rejected.
    key_raw[0] = 1'b1; tick(1);
    key_raw[0] = 1'b0; tick(1);
    key_raw[0] = 1'b1; tick(1);
    key_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("c_glitch_ignored", {9'b0, c}, 10'd0);
    end

    // C, E, B together: only C.
    key_raw = 7'b1000101;
    tick(8);
    check("priority_c_wins", dut_out, 10'b1000000_1_00);
    key_raw = '0;
    tick(8);

    // Octave up to saturation, then down to saturation.
    do_reset();
    press(1'b1);
    check("up_press1", {8'b0, up, down}, 10'b10);
    press(1'b1);
    check("up_press2", {8'b0, up, down}, 10'b10);
    press(1'b1);
    check("up_press3", {8'b0, up, down}, 10'b10);
    press(1'b0);
    check("down_press1", {8'b0, up, down}, 10'b00);
    press(1'b0);
    check("down_press2", {8'b0, up, down}, 10'b01);
    press(1'b0);
    check("down_press3", {8'b0, up, down}, 10'b01);

    // Simultaneous up and down edges cancel.
    do_reset();
    btn_up_raw = 1'b1;
    btn_down_raw = 1'b1;
    tick(10);
    check("both_held_mid", {8'b0, up, down}, 10'b00);
    btn_up_raw = 1'b0;
    btn_down_raw = 1'b0;
    tick(10);
    check("both_released_mid", {8'b0, up, down}, 10'b00);

    // Reset in the middle of a D debounce restarts from zero.
    do_reset();
    key_raw = 7'b0000010;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mid_debounce_reset_a", dut_out, 10'b0);
    tick(2);
    check("mid_debounce_reset_b", dut_out, 10'b0);
    rst = 1'b0;
    tick(6);
    check("d_after_reset_before", {9'b0, d}, 10'd0);
    tick(1);
    check("d_after_reset_at", {9'b0, d}, 10'd1);
    key_raw = '0;
    tick(10);

    // Randomized bouncy stimulus with occasional resets.
    do_reset();
    rv = '0;
    for (int j = 0; j < 9; j++) hold[j] = $urandom_range(1, 12);
    repeat (4000) begin
      @(negedge clk);
      for (int j = 0; j < 9; j++) begin
        hold[j]--;
        if (hold[j] == 0) begin
          rv[j] = ~rv[j];
          hold[j] = $urandom_range(1, 12);
        end
      end
      {btn_down_raw, btn_up_raw, key_raw} = rv;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    tick(2);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
